sha256_padder: RTL and testbench
================================

# sha256_padder

Message-formatting stage directly upstream of the SHA-256 core. It accepts an arbitrary-length message as a stream of big-endian 32-bit words and assembles 512-bit blocks. It applies FIPS 180-4 padding (0x80 byte, zero fill, 64-bit bit-length) and issues each block to the core with a one-cycle start pulse and a last-block flag. It holds each block stable until the core reports done.

## Interface
- No parameters; block geometry is fixed by constants in the shared package.
- iClk  in  1  clock, all logic on rising edge.
- iReset_n  in  1  asynchronous active-low reset.
- iWordValid  in  1  input word valid.
- oWordReady  out  1  padder can accept a word; high only in FILL.
- iWordData  in  32  message bytes; [31:24] is the earliest byte.
- iWordBytes  in  3  valid bytes in this word, 0..4, left-justified. Present only with SHA256_PADDER_BYTE_EN.
- iWordLast  in  1  final word of the message.
- oBlock  out  512  block to core; word k at [511-32k -: 32].
- oStart  out  1  one-cycle pulse; the core latches oBlock.
- oLastBlock  out  1  high while the final padded block is presented.
- iCoreDone  in  1  core finished the current block (pulse).
- oBusy  out  1  high in every state except FILL.

## Operation
- States: FILL, PAD, ISSUE, WAIT, EXTRA.
- **FILL**
  - A word is accepted when iWordValid && oWordReady. It is written at word index widx (4-bit), and the byte count grows by iWordBytes.
  - Byte count is 61 bits and wraps silently; messages of 2^61 bytes or more are unsupported.
  - Word accepted with widx=15 and iWordLast=0: go to ISSUE with oLastBlock=0, then widx resets to 0.
  - Word accepted with iWordLast=1: go to PAD.
- **PAD** (one cycle)
  - off = byte offset just past the message within the block (0..63).
  - Write 0x80 at byte off and clear all later bytes.
  - If off<=55: write the 64-bit big-endian length (bytes×8) to words 14..15, set the final flag, go to ISSUE.
  - Otherwise set need_extra and go to ISSUE with oLastBlock=0.
- **ISSUE**: oStart=1 for exactly one cycle, then WAIT.
- **WAIT**
  - Hold oBlock and oLastBlock.
  - On iCoreDone: go to EXTRA if need_extra, else to FILL (clear byte count, widx and the final flag).
- **EXTRA** (one cycle): block = 14 zero words plus the length, oLastBlock=1, clear need_extra, go to ISSUE.
- **Message ends exactly on a 64-byte boundary** (last word at widx=15, or the last word carrying 0 bytes): the data block is issued non-final. PAD then operates on a fresh block with off=0, giving 0x80…0 plus the length in one final block.
  - Sequence for this case: ISSUE→WAIT→PAD→ISSUE.
- **Ignored inputs**: iCoreDone outside WAIT; word inputs outside FILL.
- **Reset mid-operation**: all state clears immediately. The partially hashed message is discarded, and the core must be reset with it.

## Timing
- Reset values:
  - state=FILL, oWordReady=1 (combinational from state)
  - oStart=0, oLastBlock=0, oBusy=0, oBlock=0
- Throughput: one word per cycle in FILL.
- Latency:
  - 16th word accepted at cycle N → oStart at N+1.
  - Last word accepted at N → PAD at N+1, oStart at N+2.
  - iCoreDone at M → FILL at M+1; or EXTRA at M+1 and oStart at M+2.
- oStart is never high on two consecutive cycles.
- oBlock and oLastBlock are valid from the ISSUE cycle until WAIT exits.

## Configuration
- **SHA256_PADDER_BYTE_EN defined**
  - iWordBytes port present; message length is any byte count.
  - iWordBytes=0 is legal only with iWordLast, which permits the empty message.
  - Bytes beyond iWordBytes in a word are ignored and overwritten by padding.
- **SHA256_PADDER_BYTE_EN not defined**
  - Port absent; every word carries 4 bytes and the byte count increments by 4.
  - Message length is a multiple of 4, at least 4.
  - The byte-mask logic is removed; 0x80 always lands on a word boundary.

## Structure
- Shared package sha256_pkg holds:
  - state enum
  - SHA256_BLOCK_WORDS=16, SHA256_BLOCK_BITS=512, SHA256_LEN_BITS=64
  - SHA256_PAD_BYTE=8'h80, SHA256_LEN_OFFSET_MAX=55
- One natural sub-module: sha256_pad_mask.
  - Combinational: given a word and a byte offset within it, returns the word with 0x80 inserted and later bytes zeroed.
  - Used in PAD; absent when SHA256_PADDER_BYTE_EN is undefined.

## Test plan
- "abc" (one word 0x61626300, bytes=3, last) → one block:
  - word0=0x61626380, words1..14=0, word15=0x00000018
  - oLastBlock=1, oStart at N+2
- 55-byte message → single final block with 0x80 at byte 55 and word15=0x000001B8.
- 56-byte message → two blocks:
  - First: 0x80 at byte 56, oLastBlock=0.
  - Second: all zero except word15=0x000001C0, oLastBlock=1, issued two cycles after the first iCoreDone.
- 64-byte message → data block non-final, then final block word0=0x80000000, word15=0x00000200.
- Backpressure: iWordValid held high through WAIT → oWordReady=0, no word consumed; iCoreDone pulsed in FILL ignored.
- Reset asserted in WAIT → same cycle: oBusy=0, oStart=0, oWordReady=1. A subsequent "abc" produces the correct block.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 message padder.
package sha256_pkg;
  localparam int         SHA256_BLOCK_WORDS    = 16;
  localparam int         SHA256_BLOCK_BITS     = 512;
  localparam int         SHA256_LEN_BITS       = 64;
  localparam logic [7:0] SHA256_PAD_BYTE       = 8'h80;
  localparam int         SHA256_LEN_OFFSET_MAX = 55;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_ISSUE,
    S_WAIT,
    S_EXTRA
  } state_e;
endpackage

// File: rtl/sha256_pad_mask.sv
// Inserts the 0x80 pad byte at a byte offset within a big-endian word and zeroes later bytes.
// Only instantiated when SHA256_PADDER_BYTE_EN is defined.
module sha256_pad_mask
  import sha256_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(off_i))
        word_o[31-8*b -: 8] = word_i[31-8*b -: 8];
      else if (b == int'(off_i))
        word_o[31-8*b -: 8] = SHA256_PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs 32-bit words into 512-bit blocks and hands them to the core.
// Define SHA256_PADDER_BYTE_EN to accept partial words via iWordBytes.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic                         iClk,
  input  logic                         iReset_n,
  input  logic                         iWordValid,
  output logic                         oWordReady,
  input  logic [31:0]                  iWordData,
`ifdef SHA256_PADDER_BYTE_EN
  input  logic [2:0]                   iWordBytes,
`endif
  input  logic                         iWordLast,
  output logic [SHA256_BLOCK_BITS-1:0] oBlock,
  output logic                         oStart,
  output logic                         oLastBlock,
  input  logic                         iCoreDone,
  output logic                         oBusy
);

  // Word k of the block lives at storage index 15-k so the packed array maps straight onto oBlock.
  state_e                                state_q, state_d;
  logic [SHA256_BLOCK_WORDS-1:0][31:0]   blk_q, blk_d;
  logic [60:0]                           len_q, len_d, len_add;
  logic [3:0]                            widx_q, widx_d;
  logic                                  need_extra_q, need_extra_d;
  logic                                  last_q, last_d;
  logic                                  pad_pend_q, pad_pend_d;
  logic [2:0]                            wbytes;
  logic [3:0]                            pad_j;
  logic [31:0]                           pad_word;
  logic [SHA256_LEN_BITS-1:0]            len_bits;

  assign len_bits = {len_q, 3'b000};
  assign pad_j    = 4'd15 - len_q[5:2];
  assign len_add  = len_q + 61'(wbytes);

`ifdef SHA256_PADDER_BYTE_EN
  assign wbytes = iWordBytes;
  sha256_pad_mask u_mask (
    .word_i (blk_q[pad_j]),
    .off_i  (len_q[1:0]),
    .word_o (pad_word)
  );
`else
  assign wbytes   = 3'd4;
  assign pad_word = {SHA256_PAD_BYTE, 24'h0};
`endif

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    len_d        = len_q;
    widx_d       = widx_q;
    need_extra_d = need_extra_q;
    last_d       = last_q;
    pad_pend_d   = pad_pend_q;
    case (state_q)
      S_FILL: begin
        if (iWordValid) begin
          blk_d[4'd15 - widx_q] = iWordData;
          len_d                 = len_add;
          widx_d                = widx_q + 4'd1;
          if (iWordLast) begin
            // A message filling the block exactly ships the data first, then pads a fresh block.
            if (widx_q == 4'd15 && len_add[5:0] == 6'd0) begin
              state_d    = S_ISSUE;
              pad_pend_d = 1'b1;
            end else begin
              state_d = S_PAD;
            end
          end else if (widx_q == 4'd15) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_PAD: begin
        for (int j = 0; j < SHA256_BLOCK_WORDS; j++) begin
          if (j == int'(pad_j))     blk_d[j] = pad_word;
          else if (j < int'(pad_j)) blk_d[j] = '0;
        end
        if (len_q[5:0] <= 6'(SHA256_LEN_OFFSET_MAX)) begin
          blk_d[1] = len_bits[63:32];
          blk_d[0] = len_bits[31:0];
          last_d   = 1'b1;
        end else begin
          need_extra_d = 1'b1;
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (iCoreDone) begin
          if (need_extra_q) begin
            state_d = S_EXTRA;
          end else if (pad_pend_q) begin
            state_d    = S_PAD;
            pad_pend_d = 1'b0;
          end else begin
            state_d = S_FILL;
            len_d   = '0;
            widx_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      S_EXTRA: begin
        blk_d        = '0;
        blk_d[1]     = len_bits[63:32];
        blk_d[0]     = len_bits[31:0];
        last_d       = 1'b1;
        need_extra_d = 1'b0;
        state_d      = S_ISSUE;
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q      <= S_FILL;
      blk_q        <= '0;
      len_q        <= '0;
      widx_q       <= '0;
      need_extra_q <= 1'b0;
      last_q       <= 1'b0;
      pad_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      len_q        <= len_d;
      widx_q       <= widx_d;
      need_extra_q <= need_extra_d;
      last_q       <= last_d;
      pad_pend_q   <= pad_pend_d;
    end
  end

  assign oWordReady = (state_q == S_FILL);
  assign oBusy      = (state_q != S_FILL);
  assign oStart     = (state_q == S_ISSUE);
  assign oLastBlock = last_q;
  assign oBlock     = blk_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder; adds partial-word cases when SHA256_PADDER_BYTE_EN is defined.
module tb_sha256_padder;
  logic         iClk = 1'b0;
  logic         iReset_n = 1'b0;
  logic         iWordValid = 1'b0;
  logic         oWordReady;
  logic [31:0]  iWordData = '0;
  logic [2:0]   iWordBytes = 3'd4;
  logic         iWordLast = 1'b0;
  logic [511:0] oBlock;
  logic         oStart;
  logic         oLastBlock;
  logic         iCoreDone = 1'b0;
  logic         oBusy;

  int tests = 0;
  int fails = 0;

  always #5 iClk = ~iClk;

  sha256_padder dut (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .iWordValid (iWordValid),
    .oWordReady (oWordReady),
    .iWordData  (iWordData),
`ifdef SHA256_PADDER_BYTE_EN
    .iWordBytes (iWordBytes),
`endif
    .iWordLast  (iWordLast),
    .oBlock     (oBlock),
    .oStart     (oStart),
    .oLastBlock (oLastBlock),
    .iCoreDone  (iCoreDone),
    .oBusy      (oBusy)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Message byte i has value i, so word k carries bytes 4k..4k+3.
  function automatic logic [31:0] dw(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  function automatic logic [511:0] setw(input logic [511:0] b, input int k, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*k -: 32] = w;
    return r;
  endfunction

  task automatic send(input logic [31:0] d, input logic [2:0] nb, input logic last);
    iWordValid = 1'b1;
    iWordData  = d;
    iWordBytes = nb;
    iWordLast  = last;
    @(posedge iClk); #1;
    iWordValid = 1'b0;
    iWordLast  = 1'b0;
  endtask

  task automatic send_msg(input int n, input logic [2:0] lastb);
    for (int i = 0; i < n; i++)
      send(dw(i), (i == n-1) ? lastb : 3'd4, i == n-1);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!oStart && n < 40) begin
      @(posedge iClk); #1;
      n++;
    end
    if (!oStart) chk("start_timeout", 512'd0, 512'd1);
  endtask

  task automatic finish_block(input string tag);
    @(posedge iClk); #1;
    chk({tag, "_start_1cyc"}, oStart, 1'b0);
    iCoreDone = 1'b1;
    @(posedge iClk); #1;
    iCoreDone = 1'b0;
  endtask

  task automatic expect_block(input string tag, input logic [511:0] eb, input int elat, input logic elast);
    int n;
    wait_start(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_blk"}, oBlock, eb);
    chk({tag, "_last"}, oLastBlock, elast);
    finish_block(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] e, e2;
    int n;

    #1;
    chk("rst_start", oStart, 1'b0);
    chk("rst_last",  oLastBlock, 1'b0);
    chk("rst_busy",  oBusy, 1'b0);
    chk("rst_ready", oWordReady, 1'b1);
    chk("rst_block", oBlock, 512'd0);
    #10 iReset_n = 1'b1;
    @(posedge iClk); #1;

    // One 4-byte word, with backpressure held through WAIT.
    e = '0;
    e = setw(e, 0, 32'h61626364);
    e = setw(e, 1, 32'h80000000);
    e = setw(e, 15, 32'h00000020);
    send(32'h61626364, 3'd4, 1'b1);
    wait_start(n);
    chk("abcd_lat", n, 1);
    chk("abcd_blk", oBlock, e);
    chk("abcd_last", oLastBlock, 1'b1);
    @(posedge iClk); #1;
    chk("abcd_start_1cyc", oStart, 1'b0);
    iWordValid = 1'b1;
    iWordData  = 32'hDEADBEEF;
    repeat (3) @(posedge iClk);
    #1;
    chk("bp_ready", oWordReady, 1'b0);
    chk("bp_busy",  oBusy, 1'b1);
    chk("bp_hold_blk", oBlock, e);
    chk("bp_hold_last", oLastBlock, 1'b1);
    iWordValid = 1'b0;
    iCoreDone  = 1'b1;
    @(posedge iClk); #1;
    iCoreDone = 1'b0;
    chk("post_done_ready", oWordReady, 1'b1);
    chk("post_done_last",  oLastBlock, 1'b0);
    iCoreDone = 1'b1;
    @(posedge iClk); #1;
    iCoreDone = 1'b0;
    chk("fill_done_busy",  oBusy, 1'b0);
    chk("fill_done_start", oStart, 1'b0);

    // 52 bytes: pad and length fit in the same block.
    e = '0;
    for (int k = 0; k < 13; k++) e = setw(e, k, dw(k));
    e = setw(e, 13, 32'h80000000);
    e = setw(e, 15, 32'h000001A0);
    send_msg(13, 3'd4);
    expect_block("m52", e, 1, 1'b1);

    // 56 bytes: pad fits, length spills into an extra block.
    e = '0;
    for (int k = 0; k < 14; k++) e = setw(e, k, dw(k));
    e = setw(e, 14, 32'h80000000);
    e2 = setw(512'd0, 15, 32'h000001C0);
    send_msg(14, 3'd4);
    expect_block("m56a", e, 1, 1'b0);
    expect_block("m56b", e2, 1, 1'b1);

    // 64 bytes: data block issued on the 16th word, then a pad-only block.
    e = '0;
    for (int k = 0; k < 16; k++) e = setw(e, k, dw(k));
    e2 = setw(512'd0, 0, 32'h80000000);
    e2 = setw(e2, 15, 32'h00000200);
    send_msg(16, 3'd4);
    expect_block("m64a", e, 0, 1'b0);
    expect_block("m64b", e2, 1, 1'b1);

`ifdef SHA256_PADDER_BYTE_EN
    // "abc" with a junk trailing byte that padding must overwrite.
    e = setw(512'd0, 0, 32'h61626380);
    e = setw(e, 15, 32'h00000018);
    send(32'h616263FF, 3'd3, 1'b1);
    expect_block("abc", e, 1, 1'b1);

    e = '0;
    for (int k = 0; k < 13; k++) e = setw(e, k, dw(k));
    e = setw(e, 13, 32'h34353680);
    e = setw(e, 15, 32'h000001B8);
    send_msg(14, 3'd3);
    expect_block("m55", e, 1, 1'b1);

    e = setw(512'd0, 0, 32'h80000000);
    send(32'hFFFFFFFF, 3'd0, 1'b1);
    expect_block("empty", e, 1, 1'b1);
`endif

    // Reset while the core is working on a block.
    send(32'h11223344, 3'd4, 1'b1);
    wait_start(n);
    @(posedge iClk); #1;
    chk("pre_rst_busy", oBusy, 1'b1);
    iReset_n = 1'b0;
    #1;
    chk("wrst_busy",  oBusy, 1'b0);
    chk("wrst_start", oStart, 1'b0);
    chk("wrst_ready", oWordReady, 1'b1);
    chk("wrst_last",  oLastBlock, 1'b0);
    chk("wrst_block", oBlock, 512'd0);
    @(posedge iClk); #1;
    iReset_n = 1'b1;
    @(posedge iClk); #1;
    e = '0;
    e = setw(e, 0, 32'h61626364);
    e = setw(e, 1, 32'h80000000);
    e = setw(e, 15, 32'h00000020);
    send(32'h61626364, 3'd4, 1'b1);
    expect_block("post_rst", e, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
